// File: rtl/gru_seq_ctrl.sv
// Timestep sequencer for the GRU element datapath: feeds HIDDEN_SIZE slots per step,
// tracks them through the fixed-latency cell and ping-pongs the hidden-state banks.
module gru_seq_ctrl #(
    parameter int HIDDEN_SIZE = 32,
    parameter int IDX_WIDTH   = 5,
    parameter int STEP_WIDTH  = 8,
    parameter int GRU_LAT     = 40,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STEP_WIDTH-1:0] cfg_seq_len,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  feed_valid,
    output logic [IDX_WIDTH-1:0]  feed_idx,
    output logic [STEP_WIDTH-1:0] feed_step,
    output logic                  rd_bank,
    output logic                  wb_valid,
    output logic [IDX_WIDTH-1:0]  wb_idx,
    output logic                  wb_bank,
    output logic                  step_done,
    output logic                  busy,
    output logic                  done,
    output logic                  final_bank
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(HIDDEN_SIZE - 1);

    state_t                state, state_nxt;
    logic [STEP_WIDTH-1:0] seq_len, step;
    logic [IDX_WIDTH-1:0]  idx;
    logic [CNT_WIDTH-1:0]  inflight;
    logic                  bank;
    logic [GRU_LAT:1]      vld_pipe;
    logic [IDX_WIDTH-1:0]  idx_pipe [GRU_LAT:1];

    logic feed, last_feed, last_step, drain_ok;

    assign feed      = (state == FEED) && src_valid;
    assign last_feed = feed && (idx == LAST_IDX);
    assign last_step = (step == seq_len - STEP_WIDTH'(1));
    assign drain_ok  = (state == DRAIN) && (inflight == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (cfg_seq_len != '0) ? FEED : DONE;
            FEED:  if (last_feed) state_nxt = DRAIN;
            DRAIN: if (drain_ok) state_nxt = last_step ? DONE : FEED;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_len  <= '0;
            step     <= '0;
            idx      <= '0;
            bank     <= 1'b0;
            inflight <= '0;
        end else begin
            if (state == IDLE && start) begin
                seq_len <= cfg_seq_len;
                step    <= '0;
                idx     <= '0;
            end
            if (feed) idx <= last_feed ? '0 : idx + 1'b1;
            // Bank swap happens only between steps; the last step leaves it for final_bank.
            if (drain_ok && !last_step) begin
                step <= step + 1'b1;
                bank <= ~bank;
            end
            case ({feed, wb_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Slot tracker mirroring the cell latency; bubbles travel as valid=0 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= GRU_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[GRU_LAT-1:1], feed};
            idx_pipe[1] <= feed ? idx : '0;
            for (int i = 2; i <= GRU_LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
        end
    end

    assign src_ready  = (state == FEED);
    assign feed_valid = feed;
    assign feed_idx   = idx;
    assign feed_step  = step;
    assign rd_bank    = bank;
    assign wb_valid   = vld_pipe[GRU_LAT];
    assign wb_idx     = idx_pipe[GRU_LAT];
    assign wb_bank    = ~bank;
    assign step_done  = wb_valid && (wb_idx == LAST_IDX);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign final_bank = (state == DONE) && !bank;
endmodule
